regf_cmd_loader: RTL and testbench

Command loader sitting directly upstream of `Internal_Regfile`. It accepts a 64-bit command descriptor plus an optional short write payload from the host side over valid/ready handshakes. It serialises them into byte writes on the regfile write port: descriptor to addresses 1..8, payload from address 9 upward. It then holds a configuration-valid level toward the engine until the engine acknowledges.

---
 rtl/regf_cmd_loader.sv | 144 ++++++++++++++
 tb/tb_regf_cmd_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regf_cmd_loader.sv
// Command loader: serialises a 64-bit descriptor and an optional payload into
// byte writes on the regfile port, then holds cfg_valid until the engine is done.
//
// state | meaning
// IDLE  | waiting for a descriptor (o_desc_ready=1)
// DESC  | writing descriptor bytes 0..7 to DESC_BASE..DESC_BASE+7
// PLD   | accepting payload bytes and writing them from PLD_BASE upward
// HOLD  | regfile configured, o_cfg_valid=1 until i_engine_done
module regf_cmd_loader #(
  parameter int DESC_BASE = 1,
  parameter int PLD_BASE  = 9,
  parameter int MAX_PLD   = 23
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_desc_valid,
  output logic        o_desc_ready,
  input  logic [63:0] i_desc,
  input  logic [4:0]  i_pld_len,
  input  logic        i_pld_valid,
  output logic        o_pld_ready,
  input  logic [7:0]  i_pld_data,
  output logic        o_wr_en,
  output logic [4:0]  o_addr,
  output logic [7:0]  o_data,
  output logic        o_cfg_valid,
  input  logic        i_engine_done,
  output logic        o_err,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, DESC, PLD, HOLD} state_t;

  state_t      state, next_state;
  logic [63:0] desc_q;
  logic [4:0]  len_q;
  logic [2:0]  byte_cnt;
  logic [2:0]  byte_nxt;
  logic [4:0]  pld_cnt;
  logic        desc_acc;
  logic        len_bad;
  logic        pld_acc;

  logic        wr_en_d;
  logic [4:0]  addr_d;
  logic [7:0]  data_d;
  logic        cfg_valid_d;
  logic        err_d;
  logic        busy_d;

  assign o_desc_ready = (state == IDLE);
  assign o_pld_ready  = (state == PLD) && (pld_cnt < len_q);
  assign desc_acc     = i_desc_valid && o_desc_ready;
  assign len_bad      = (i_pld_len > 5'(MAX_PLD));
  assign pld_acc      = i_pld_valid && o_pld_ready;
  assign byte_nxt     = byte_cnt + 3'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (desc_acc && !len_bad) next_state = DESC;
      DESC: if (byte_cnt == 3'd7) next_state = (len_q != 5'd0) ? PLD : HOLD;
      PLD:  if (pld_cnt == len_q) next_state = HOLD;
      HOLD: if (i_engine_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs; addr/data hold when no write is issued.
  always_comb begin
    wr_en_d = 1'b0;
    addr_d  = o_addr;
    data_d  = o_data;
    err_d   = 1'b0;
    case (state)
      IDLE: begin
        if (desc_acc) begin
          if (len_bad) begin
            err_d = 1'b1;
          end else begin
            wr_en_d = 1'b1;
            addr_d  = 5'(DESC_BASE);
            data_d  = i_desc[7:0];
          end
        end
      end
      DESC: begin
        if (byte_cnt != 3'd7) begin
          wr_en_d = 1'b1;
          addr_d  = 5'(DESC_BASE) + {2'b00, byte_nxt};
          data_d  = desc_q[{byte_nxt, 3'b000} +: 8];
        end
      end
      PLD: begin
        if (pld_acc) begin
          wr_en_d = 1'b1;
          addr_d  = 5'(PLD_BASE) + pld_cnt;
          data_d  = i_pld_data;
        end
      end
      default: ;
    endcase
    cfg_valid_d = (next_state == HOLD);
    busy_d      = (next_state != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      desc_q      <= '0;
      len_q       <= '0;
      byte_cnt    <= '0;
      pld_cnt     <= '0;
      o_wr_en     <= 1'b0;
      o_addr      <= '0;
      o_data      <= '0;
      o_cfg_valid <= 1'b0;
      o_err       <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_wr_en     <= wr_en_d;
      o_addr      <= addr_d;
      o_data      <= data_d;
      o_cfg_valid <= cfg_valid_d;
      o_err       <= err_d;
      o_busy      <= busy_d;
      if (desc_acc && !len_bad) begin
        desc_q   <= i_desc;
        len_q    <= i_pld_len;
        byte_cnt <= 3'd0;
        pld_cnt  <= 5'd0;
      end else if (state == DESC) begin
        byte_cnt <= byte_nxt;
      end else if (pld_acc) begin
        pld_cnt <= pld_cnt + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_regf_cmd_loader.sv
// Bench for regf_cmd_loader: edge-indexed reference of the load sequence plus a
// regfile image rebuilt from expected writes and compared with observed writes.
module tb_regf_cmd_loader;

  localparam int DESC_BASE = 1;
  localparam int PLD_BASE  = 9;
  localparam int MAX_PLD   = 23;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_desc_valid = 1'b0;
  logic        o_desc_ready;
  logic [63:0] i_desc = '0;
  logic [4:0]  i_pld_len = '0;
  logic        i_pld_valid = 1'b0;
  logic        o_pld_ready;
  logic [7:0]  i_pld_data = '0;
  logic        o_wr_en;
  logic [4:0]  o_addr;
  logic [7:0]  o_data;
  logic        o_cfg_valid;
  logic        i_engine_done = 1'b0;
  logic        o_err;
  logic        o_busy;

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0] exp_rf  [32];
  logic [7:0] dut_rf  [32];
  logic [7:0] pld_buf [32];

  regf_cmd_loader #(.DESC_BASE(DESC_BASE), .PLD_BASE(PLD_BASE), .MAX_PLD(MAX_PLD)) dut (
    .clk(clk), .reset(reset),
    .i_desc_valid(i_desc_valid), .o_desc_ready(o_desc_ready),
    .i_desc(i_desc), .i_pld_len(i_pld_len),
    .i_pld_valid(i_pld_valid), .o_pld_ready(o_pld_ready), .i_pld_data(i_pld_data),
    .o_wr_en(o_wr_en), .o_addr(o_addr), .o_data(o_data),
    .o_cfg_valid(o_cfg_valid), .i_engine_done(i_engine_done),
    .o_err(o_err), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // The regfile samples on the rising edge; the negedge before it sees the same data.
  always @(negedge clk) if (o_wr_en) dut_rf[o_addr] = o_data;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_en"}, o_wr_en, 0);
    chk({tag, "_addr"}, o_addr, 0);
    chk({tag, "_data"}, o_data, 0);
    chk({tag, "_cfg_valid"}, o_cfg_valid, 0);
    chk({tag, "_err"}, o_err, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_pld_ready"}, o_pld_ready, 0);
    chk({tag, "_desc_ready"}, o_desc_ready, 1);
  endtask

  task automatic cmp_rf();
    @(negedge clk);
    for (int i = 0; i < 32; i++) chk($sformatf("regfile_%0d", i), dut_rf[i], exp_rf[i]);
    @(posedge clk); #1;
  endtask

  // One load from the descriptor accept edge E0 onward. mode: 0 continuous,
  // 1 valid on even edges only, 2 random valid. rst_at: edge after which reset
  // is pulsed (-1 none). done_at: edge at which a stray engine_done is driven.
  task automatic run_txn(input logic [63:0] d, input int len, input int mode,
                         input int rst_at, input int done_at);
    int acc, last_acc;
    bit fin, accepted, exp_wr, exp_cfg;
    logic [4:0] ea;
    logic [7:0] ed;
    i_desc = d;
    i_pld_len = 5'(len);
    i_desc_valid = 1'b1;
    i_pld_valid = 1'b0;
    chk("desc_ready_idle", o_desc_ready, 1);
    acc = 0; last_acc = -1; fin = 1'b0;
    ea = '0; ed = '0;
    for (int j = 0; j < 200 && !fin; j++) begin
      if (j > 0) begin
        case (mode)
          0: i_pld_valid = 1'b1;
          1: i_pld_valid = (j % 2 == 0);
          default: i_pld_valid = 1'($urandom_range(0, 1));
        endcase
        i_pld_data = (acc < len) ? pld_buf[acc] : 8'($urandom);
        i_engine_done = (j == done_at);
        chk("pld_ready", o_pld_ready, (j >= 9 && acc < len));
      end
      @(posedge clk); #1;
      i_desc_valid = 1'b0;
      accepted = (j >= 9) && (acc < len) && i_pld_valid;
      exp_wr = accepted || (j <= 7);
      if (accepted) begin
        ea = 5'(PLD_BASE + acc);
        ed = pld_buf[acc];
        acc++;
        last_acc = j;
      end else if (j <= 7) begin
        ea = 5'(DESC_BASE + j);
        ed = d[8*j +: 8];
      end
      exp_cfg = (len == 0) ? (j >= 8) : (acc == len && j > last_acc);
      chk("wr_en", o_wr_en, exp_wr);
      if (exp_wr) begin
        chk("wr_addr", o_addr, ea);
        chk("wr_data", o_data, ed);
      end
      chk("cfg_valid", o_cfg_valid, exp_cfg);
      chk("busy", o_busy, 1);
      chk("err_quiet", o_err, 0);
      chk("desc_ready_busy", o_desc_ready, 0);
      if (j == rst_at) begin
        #2 reset = 1'b0;
        #1 chk_all_zero("async_reset");
        @(posedge clk); #3 reset = 1'b1;
        @(posedge clk); #1;
        fin = 1'b1;
      end else begin
        if (exp_wr) exp_rf[ea] = ed;
        if (exp_cfg) fin = 1'b1;
      end
    end
    if (!fin) chk("txn_timeout", 0, 1);
    i_pld_valid = 1'b0;
    i_engine_done = 1'b0;
  endtask

  // Hold HOLD with a descriptor offered for blk cycles, then release with engine_done.
  task automatic finish_hold(input int blk);
    for (int i = 0; i < blk; i++) begin
      i_desc = {$urandom, $urandom};
      i_pld_len = 5'd0;
      i_desc_valid = 1'b1;
      @(posedge clk); #1;
      chk("hold_desc_ready", o_desc_ready, 0);
      chk("hold_cfg_valid", o_cfg_valid, 1);
      chk("hold_wr_en", o_wr_en, 0);
      chk("hold_busy", o_busy, 1);
    end
    i_desc_valid = 1'b0;
    i_engine_done = 1'b1;
    @(posedge clk); #1;
    i_engine_done = 1'b0;
    chk("done_cfg_valid", o_cfg_valid, 0);
    chk("done_desc_ready", o_desc_ready, 1);
    chk("done_busy", o_busy, 0);
    chk("done_wr_en", o_wr_en, 0);
  endtask

  task automatic reject(input int len);
    i_desc = {$urandom, $urandom};
    i_pld_len = 5'(len);
    i_desc_valid = 1'b1;
    chk("rej_desc_ready_pre", o_desc_ready, 1);
    @(posedge clk); #1;
    i_desc_valid = 1'b0;
    chk("rej_err", o_err, 1);
    chk("rej_wr_en", o_wr_en, 0);
    chk("rej_busy", o_busy, 0);
    chk("rej_cfg_valid", o_cfg_valid, 0);
    chk("rej_desc_ready", o_desc_ready, 1);
  endtask

  initial begin
    logic [63:0] d;
    int len;
    for (int i = 0; i < 32; i++) begin
      exp_rf[i] = 8'h00;
      dut_rf[i] = 8'h00;
      pld_buf[i] = 8'h00;
    end

    #12;
    chk_all_zero("reset_state");
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // Descriptor only, stray engine_done during DESC, HOLD blocking.
    run_txn(64'hAC_C0_A0_7B_15_01_B1_A0, 0, 0, -1, 3);
    finish_hold(3);
    cmp_rf();

    // Three payload bytes back-to-back.
    pld_buf[0] = 8'h11; pld_buf[1] = 8'h22; pld_buf[2] = 8'h33;
    run_txn(64'h0123_4567_89AB_CDEF, 3, 0, -1, -1);
    finish_hold(1);

    // Two payload bytes with valid toggling.
    pld_buf[0] = 8'h5A; pld_buf[1] = 8'hC3;
    run_txn(64'hFEDC_BA98_7654_3210, 2, 1, -1, -1);
    finish_hold(0);
    cmp_rf();

    // Over-length descriptor rejected, next one accepted straight away.
    reject(24);
    pld_buf[0] = 8'h9E;
    run_txn(64'h1122_3344_5566_7788, 1, 0, -1, -1);
    finish_hold(1);
    reject(31);
    run_txn(64'h8877_6655_4433_2211, 0, 0, -1, -1);
    finish_hold(0);
    cmp_rf();

    // Maximum payload, continuous.
    for (int i = 0; i < MAX_PLD; i++) pld_buf[i] = 8'($urandom);
    run_txn({$urandom, $urandom}, MAX_PLD, 0, -1, -1);
    finish_hold(1);
    cmp_rf();

    // Randomised loads.
    for (int t = 0; t < 6; t++) begin
      d = {$urandom, $urandom};
      len = $urandom_range(0, MAX_PLD);
      for (int i = 0; i < MAX_PLD; i++) pld_buf[i] = 8'($urandom);
      run_txn(d, len, 2, -1, -1);
      finish_hold($urandom_range(0, 2));
    end
    cmp_rf();

    // Reset while descriptor byte 4 is presented, then a full fresh load.
    pld_buf[0] = 8'hA1; pld_buf[1] = 8'hB2;
    run_txn(64'hDEAD_BEEF_CAFE_F00D, 2, 0, 4, -1);
    chk_all_zero("post_reset");
    cmp_rf();
    run_txn(64'h0F1E_2D3C_4B5A_6978, 2, 0, -1, -1);
    finish_hold(1);
    cmp_rf();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
